// File: rtl/stream_pkt_gen.sv
// AXI-Stream packet source: each accepted command becomes one packet of
// counting-pattern beats (seed, seed+1, ...) with a programmable last-beat keep.
module stream_pkt_gen #(
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [DATA_WIDTH-1:0]   cmd_seed,
    input  logic [DATA_WIDTH/8-1:0] cmd_keep,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [DEST_WIDTH-1:0]   cmd_dest,
    output logic                    t_valid,
    input  logic                    t_ready,
    output logic [DATA_WIDTH-1:0]   t_data,
    output logic [DATA_WIDTH/8-1:0] t_strb,
    output logic [DATA_WIDTH/8-1:0] t_keep,
    output logic                    t_last,
    output logic [ID_WIDTH-1:0]     t_id,
    output logic [DEST_WIDTH-1:0]   t_dest,
    output logic [USER_WIDTH-1:0]   t_user,
    output logic                    busy,
    output logic [31:0]             pkt_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state, state_next;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic [LEN_WIDTH-1:0]  beat_next;
    logic                  accept;
    logic                  xfer;
    logic                  last_xfer;

    // Beat index carried on t_user, truncated or zero-extended to fit.
    function automatic logic [USER_WIDTH-1:0] user_of(input logic [LEN_WIDTH-1:0] idx);
        return USER_WIDTH'(idx);
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] keep_of(input logic is_last,
                                                      input logic [KEEP_WIDTH-1:0] last_keep);
        return is_last ? last_keep : {KEEP_WIDTH{1'b1}};
    endfunction

    // Handshake decode; cmd_ready opens in the last-beat transfer cycle so the
    // next packet follows with no idle cycle.
    always_comb begin
        state_next = state;
        xfer       = t_valid && t_ready;
        last_xfer  = xfer && t_last;
        cmd_ready  = (state == IDLE) || last_xfer;
        accept     = cmd_valid && cmd_ready;
        beat_next  = beat_idx + LEN_WIDTH'(1);
        case (state)
            IDLE: if (accept) state_next = SEND;
            SEND: if (last_xfer && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy = (state == SEND);

    // Output beat register: loaded on accept, advanced on each transfer,
    // held while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_valid   <= 1'b0;
            t_last    <= 1'b0;
            t_data    <= '0;
            t_keep    <= '0;
            t_strb    <= '0;
            t_id      <= '0;
            t_dest    <= '0;
            t_user    <= '0;
            len_q     <= '0;
            keep_q    <= '0;
            beat_idx  <= '0;
            pkt_count <= '0;
        end else begin
            if (accept) begin
                t_valid  <= 1'b1;
                t_data   <= cmd_seed;
                t_last   <= (cmd_len == '0);
                t_keep   <= keep_of(cmd_len == '0, cmd_keep);
                t_strb   <= keep_of(cmd_len == '0, cmd_keep);
                t_id     <= cmd_id;
                t_dest   <= cmd_dest;
                t_user   <= '0;
                len_q    <= cmd_len;
                keep_q   <= cmd_keep;
                beat_idx <= '0;
            end else if (last_xfer) begin
                t_valid <= 1'b0;
                t_last  <= 1'b0;
            end else if (xfer) begin
                beat_idx <= beat_next;
                t_data   <= t_data + DATA_WIDTH'(1);
                t_last   <= (beat_next == len_q);
                t_keep   <= keep_of(beat_next == len_q, keep_q);
                t_strb   <= keep_of(beat_next == len_q, keep_q);
                t_user   <= user_of(beat_next);
            end

            if (last_xfer) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule
